// File: rtl/branch_commit_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_commit_queue_pkg
//  Description : Shared types and constants for the branch commit queue:
//                address/data types, boolean constants, default geometry,
//                the per-entry record and the fall-through PC helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_commit_queue_pkg;

  localparam int   BCQ_DEPTH = 8;
  localparam int   BCQ_TAG_W = 3;
  localparam logic TRUE      = 1'b1;
  localparam logic FALSE     = 1'b0;

  typedef logic [31:0] ADDR_TYPE;
  typedef logic [31:0] DATA_TYPE;

  // One in-flight branch: prediction captured at dispatch, outcome at resolve.
  typedef struct packed {
    logic     valid;
    logic     is_br;
    ADDR_TYPE pc;
    logic     pred_jump;
    ADDR_TYPE pred_target;
    logic     resolved;
    logic     taken;
    ADDR_TYPE target;
  } bcq_entry_t;

  // Sequential fetch address after a not-taken branch (wraps at 2^32).
  function automatic ADDR_TYPE bcq_fallthrough(input ADDR_TYPE pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_commit_queue.sv
`default_nettype none
// ============================================================================
//  Module      : branch_commit_queue
//  Description : In-order queue of in-flight branches. Records predictions at
//                dispatch, takes out-of-order resolutions, retires in program
//                order, trains the predictor and raises rollback on mispredict.
//                Optional macro BCQ_STATS_EN adds retire/mispredict counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_commit_queue
  import branch_commit_queue_pkg::*;
#(
  parameter int DEPTH = BCQ_DEPTH,
  parameter int TAG_W = BCQ_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid,
  input  logic             alloc_is_br,
  input  logic [31:0]      alloc_pc,
  input  logic             alloc_pred_jump,
  input  logic [31:0]      alloc_pred_target,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  input  logic             commit_ok,
  output logic             upd_ena,
  output logic             upd_hit,
  output logic [31:0]      upd_pc,
  output logic             rollback,
  output logic [31:0]      rollback_pc,
`ifdef BCQ_STATS_EN
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts,
`endif
  output logic [TAG_W:0]   count
);

  bcq_entry_t       entries_q [DEPTH];
  bcq_entry_t       entries_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic             upd_ena_q, upd_ena_d;
  logic             upd_hit_q, upd_hit_d;
  ADDR_TYPE         upd_pc_q, upd_pc_d;
  logic             rollback_q, rollback_d;
  ADDR_TYPE         rollback_pc_q, rollback_pc_d;

  bcq_entry_t       head_entry;
  logic             do_push;
  logic             do_pop;
  logic             mispredict;

`ifdef BCQ_STATS_EN
  logic [31:0]      stat_branches_q, stat_branches_d;
  logic [31:0]      stat_mispredicts_q, stat_mispredicts_d;
`endif

  assign alloc_ready = (count_q != (TAG_W+1)'(DEPTH));
  assign alloc_tag   = tail_q;
  assign count       = count_q;
  assign upd_ena     = upd_ena_q;
  assign upd_hit     = upd_hit_q;
  assign upd_pc      = upd_pc_q;
  assign rollback    = rollback_q;
  assign rollback_pc = rollback_pc_q;
`ifdef BCQ_STATS_EN
  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

  // Next-state: push at tail, resolve by tag, retire at head, flush after rollback.
  always_comb begin
    entries_d     = entries_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    upd_ena_d     = FALSE;
    upd_hit_d     = upd_hit_q;
    upd_pc_d      = upd_pc_q;
    rollback_d    = FALSE;
    rollback_pc_d = rollback_pc_q;
`ifdef BCQ_STATS_EN
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
`endif

    head_entry = entries_q[head_q];
    // While a rollback is on the outputs the queue holds only wrong-path work.
    do_pop  = head_entry.valid && head_entry.resolved && commit_ok && !rollback_q;
    do_push = alloc_valid && alloc_ready && !rollback_q;
    mispredict = (head_entry.taken != head_entry.pred_jump) ||
                 (head_entry.taken && (head_entry.target != head_entry.pred_target));

    if (res_valid && entries_q[res_tag].valid) begin
      entries_d[res_tag].resolved = TRUE;
      entries_d[res_tag].taken    = res_taken;
      entries_d[res_tag].target   = res_target;
    end

    if (do_pop) begin
      entries_d[head_q].valid = FALSE;
      head_d    = head_q + TAG_W'(1);
      upd_ena_d = head_entry.is_br;
      upd_hit_d = head_entry.taken;
      upd_pc_d  = head_entry.pc;
      if (mispredict) begin
        rollback_d    = TRUE;
        rollback_pc_d = head_entry.taken ? head_entry.target
                                         : bcq_fallthrough(head_entry.pc);
      end
`ifdef BCQ_STATS_EN
      if (head_entry.is_br) stat_branches_d = stat_branches_q + 32'd1;
      if (mispredict)       stat_mispredicts_d = stat_mispredicts_q + 32'd1;
`endif
    end

    if (do_push) begin
      entries_d[tail_q] = '{valid: TRUE, is_br: alloc_is_br, pc: alloc_pc,
                            pred_jump: alloc_pred_jump, pred_target: alloc_pred_target,
                            resolved: FALSE, taken: FALSE, target: '0};
      tail_d = tail_q + TAG_W'(1);
    end

    count_d = count_q + {{TAG_W{1'b0}}, do_push} - {{TAG_W{1'b0}}, do_pop};

    if (rollback_q) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].valid    = FALSE;
        entries_d[i].resolved = FALSE;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      upd_ena_q     <= FALSE;
      upd_hit_q     <= FALSE;
      upd_pc_q      <= '0;
      rollback_q    <= FALSE;
      rollback_pc_q <= '0;
`ifdef BCQ_STATS_EN
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
`endif
    end else begin
      entries_q     <= entries_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      upd_ena_q     <= upd_ena_d;
      upd_hit_q     <= upd_hit_d;
      upd_pc_q      <= upd_pc_d;
      rollback_q    <= rollback_d;
      rollback_pc_q <= rollback_pc_d;
`ifdef BCQ_STATS_EN
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_commit_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_commit_queue
//  Description : Self-checking bench for branch_commit_queue: directed
//                scenarios with literal expectations, then randomized traffic
//                against a queue-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_commit_queue;

  localparam int DEPTH = 8;
  localparam int TAG_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             alloc_valid, alloc_is_br, alloc_pred_jump;
  logic [31:0]      alloc_pc, alloc_pred_target;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             res_valid, res_taken;
  logic [TAG_W-1:0] res_tag;
  logic [31:0]      res_target;
  logic             commit_ok;
  logic             upd_ena, upd_hit, rollback;
  logic [31:0]      upd_pc, rollback_pc;
  logic [TAG_W:0]   count;
`ifdef BCQ_STATS_EN
  logic [31:0]      stat_branches, stat_mispredicts;
`endif

  branch_commit_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_is_br(alloc_is_br), .alloc_pc(alloc_pc),
    .alloc_pred_jump(alloc_pred_jump), .alloc_pred_target(alloc_pred_target),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken), .res_target(res_target),
    .commit_ok(commit_ok),
    .upd_ena(upd_ena), .upd_hit(upd_hit), .upd_pc(upd_pc),
    .rollback(rollback), .rollback_pc(rollback_pc),
`ifdef BCQ_STATS_EN
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: program-ordered list of branches ----
  typedef struct {
    logic        is_br;
    logic [31:0] pc;
    logic        pj;
    logic [31:0] pt;
    logic        res;
    logic        tk;
    logic [31:0] tg;
    int          tag;
  } ment_t;

  ment_t       q[$];
  int          m_tail = 0;
  logic        e_ena = 0, e_hit = 0, e_rb = 0;
  logic [31:0] e_pc = 0, e_rbpc = 0;
  logic [31:0] e_stat_br = 0, e_stat_mis = 0;

  always @(posedge clk) begin : model
    bit    pop, push, mis, rb_now;
    ment_t h, n;
    if (!rst_n) begin
      q.delete();
      m_tail = 0;
      e_ena = 0; e_hit = 0; e_pc = 0; e_rb = 0; e_rbpc = 0;
      e_stat_br = 0; e_stat_mis = 0;
    end else begin
      rb_now = e_rb;
      pop  = !rb_now && (q.size() > 0) && q[0].res && commit_ok;
      push = !rb_now && alloc_valid && (q.size() < DEPTH);
      e_ena = 0;
      e_rb  = 0;
      if (pop) begin
        h = q[0];
        mis = (h.tk != h.pj) || (h.tk && (h.tg != h.pt));
        e_ena = h.is_br;
        e_hit = h.tk;
        e_pc  = h.pc;
        if (h.is_br) e_stat_br = e_stat_br + 1;
        if (mis) begin
          e_rb   = 1;
          e_rbpc = h.tk ? h.tg : h.pc + 32'd4;
          e_stat_mis = e_stat_mis + 1;
        end
      end
      if (res_valid) begin
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].tag == int'(res_tag)) begin
            n = q[i]; n.res = 1; n.tk = res_taken; n.tg = res_target; q[i] = n;
          end
        end
      end
      if (pop) void'(q.pop_front());
      if (push) begin
        n.is_br = alloc_is_br; n.pc = alloc_pc; n.pj = alloc_pred_jump;
        n.pt = alloc_pred_target; n.res = 0; n.tk = 0; n.tg = 0; n.tag = m_tail;
        q.push_back(n);
        m_tail = (m_tail + 1) % DEPTH;
      end
      if (rb_now) begin
        q.delete();
        m_tail = 0;
      end
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("alloc_ready", 32'(alloc_ready), 32'(q.size() < DEPTH));
      chk("alloc_tag", 32'(alloc_tag), 32'(m_tail));
      chk("upd_ena", 32'(upd_ena), 32'(e_ena));
      chk("rollback", 32'(rollback), 32'(e_rb));
      if (e_ena) begin
        chk("upd_hit", 32'(upd_hit), 32'(e_hit));
        chk("upd_pc", upd_pc, e_pc);
      end
      if (e_rb) chk("rollback_pc", rollback_pc, e_rbpc);
`ifdef BCQ_STATS_EN
      chk("stat_branches", stat_branches, e_stat_br);
      chk("stat_mispredicts", stat_mispredicts, e_stat_mis);
`endif
    end
  end

  // ---------------- stimulus helpers (one call = one clock cycle) ----------
  task automatic drive(input logic av, input logic ib, input logic [31:0] pc,
                       input logic pj, input logic [31:0] pt,
                       input logic rv, input logic [TAG_W-1:0] rt,
                       input logic rtk, input logic [31:0] rtg, input logic co);
    alloc_valid = av; alloc_is_br = ib; alloc_pc = pc;
    alloc_pred_jump = pj; alloc_pred_target = pt;
    res_valid = rv; res_tag = rt; res_taken = rtk; res_target = rtg;
    commit_ok = co;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, '0, 0, 0, 1);
  endtask

  task automatic push(input logic ib, input logic [31:0] pc, input logic pj, input logic [31:0] pt);
    drive(1, ib, pc, pj, pt, 0, '0, 0, 0, 1);
  endtask

  task automatic resolve(input logic [TAG_W-1:0] t, input logic tk, input logic [31:0] tg);
    drive(0, 0, 0, 0, 0, 1, t, tk, tg, 1);
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    idle();
    rst_n = 1;
  endtask

  logic [31:0] base_stat;

  initial begin
    rst_n = 0;
    alloc_valid = 0; alloc_is_br = 0; alloc_pc = 0; alloc_pred_jump = 0;
    alloc_pred_target = 0; res_valid = 0; res_tag = '0; res_taken = 0;
    res_target = 0; commit_ok = 0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst upd_ena", 32'(upd_ena), 0);
    chk("rst upd_hit", 32'(upd_hit), 0);
    chk("rst upd_pc", upd_pc, 0);
    chk("rst rollback", 32'(rollback), 0);
    chk("rst rollback_pc", rollback_pc, 0);
    chk("rst count", 32'(count), 0);
    chk("rst alloc_tag", 32'(alloc_tag), 0);
    chk("rst alloc_ready", 32'(alloc_ready), 1);
    chk_en = 1;
    rst_n = 1;

    // Fill to capacity, then an ignored ninth push
    for (int i = 0; i < 8; i++) push(1, 32'h1000 + 32'(i * 4), 0, 32'h2000);
    chk("full alloc_ready", 32'(alloc_ready), 0);
    chk("full count", 32'(count), 8);
    chk("full alloc_tag", 32'(alloc_tag), 0);
    push(1, 32'h5000, 0, 32'h6000);
    chk("ninth count", 32'(count), 8);
    chk("ninth alloc_tag", 32'(alloc_tag), 0);

    // Correct not-taken prediction
    do_reset();
    push(1, 32'h100, 0, 32'h140);
    resolve(0, 0, 32'h140);
    idle();
    chk("nt upd_ena", 32'(upd_ena), 1);
    chk("nt upd_hit", 32'(upd_hit), 0);
    chk("nt upd_pc", upd_pc, 32'h100);
    chk("nt rollback", 32'(rollback), 0);

    // Predicted not-taken, actually taken
    do_reset();
    push(1, 32'h200, 0, 32'h240);
    resolve(0, 1, 32'h180);
    idle();
    chk("mt rollback", 32'(rollback), 1);
    chk("mt rollback_pc", rollback_pc, 32'h180);
    chk("mt upd_hit", 32'(upd_hit), 1);
    idle();
    chk("mt count after", 32'(count), 0);
    chk("mt tag after", 32'(alloc_tag), 0);

    // Predicted taken, actually not-taken
    do_reset();
    push(1, 32'h300, 1, 32'h340);
    resolve(0, 0, 32'h0);
    idle();
    chk("tn rollback", 32'(rollback), 1);
    chk("tn rollback_pc", rollback_pc, 32'h304);

    // Out-of-order resolution, in-order retire
    do_reset();
    push(1, 32'hA00, 0, 32'h0);
    push(1, 32'hA10, 0, 32'h0);
    push(1, 32'hA20, 0, 32'h0);
    resolve(2, 0, 0);
    chk("ooo no retire a", 32'(upd_ena), 0);
    resolve(0, 0, 0);
    chk("ooo no retire b", 32'(upd_ena), 0);
    resolve(1, 0, 0);
    chk("ooo first pc", upd_pc, 32'hA00);
    idle();
    chk("ooo second pc", upd_pc, 32'hA10);
    idle();
    chk("ooo third pc", upd_pc, 32'hA20);
    chk("ooo third ena", 32'(upd_ena), 1);

    // JAL never trains the predictor
    do_reset();
`ifdef BCQ_STATS_EN
    base_stat = stat_branches;
`else
    base_stat = 0;
`endif
    push(0, 32'h400, 1, 32'h480);
    resolve(0, 1, 32'h480);
    idle();
    chk("jal upd_ena", 32'(upd_ena), 0);
    chk("jal rollback", 32'(rollback), 0);
`ifdef BCQ_STATS_EN
    chk("jal stat_branches", stat_branches, base_stat);
`endif
    idle();

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic             av, ib, pj, rv, rtk, co;
      logic [31:0]      pc, pt, rtg;
      logic [TAG_W-1:0] rt;
      av  = ($urandom_range(0, 99) < 60);
      ib  = ($urandom_range(0, 9) != 0);
      pc  = {$urandom_range(0, 32'h3FFF), 2'b00};
      pj  = $urandom_range(0, 1) == 1;
      pt  = pc + {$urandom_range(0, 255), 2'b00};
      rv  = ($urandom_range(0, 99) < 55);
      co  = ($urandom_range(0, 99) < 70);
      rt  = TAG_W'($urandom_range(0, DEPTH - 1));
      rtk = $urandom_range(0, 1) == 1;
      rtg = {$urandom_range(0, 32'h3FFF), 2'b00};
      if (q.size() > 0 && $urandom_range(0, 9) < 8) begin
        int k;
        k   = $urandom_range(0, q.size() - 1);
        rt  = TAG_W'(q[k].tag);
        rtk = ($urandom_range(0, 9) == 0) ? ~q[k].pj : q[k].pj;
        rtg = ($urandom_range(0, 9) == 0) ? q[k].pt + 32'd8 : q[k].pt;
      end
      rst_n = ($urandom_range(0, 499) != 0);
      drive(av, ib, pc, pj, pt, rv, rt, rtk, rtg, co);
    end
    rst_n = 1;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
